// File: rtl/unified_reservation_station.sv
// unified_reservation_station
// Parametrised reservation station between rename and one functional unit.
// Entries capture operands from any CDB channel. One ready entry per cycle
// moves into a registered valid/ready issue stage. A flush from commit
// clears the station.
// Optional feature macro: RS_AGE_SELECT_EN
//   defined     -> oldest-first select using a DEPTHxDEPTH age matrix
//   not defined -> lowest-index eligible entry is selected
module unified_reservation_station #(
  parameter int WIDTH     = 31,
  parameter int ROB       = 2,
  parameter int CTRL      = 7,
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           globalReset_n,
  input  logic                           allocValid,
  output logic                           allocReady,
  input  logic [CTRL:0]                  allocCtrl,
  input  logic [ROB:0]                   allocRob,
  input  logic                           allocRdy1,
  input  logic                           allocRdy2,
  input  logic [WIDTH:0]                 allocVal1,
  input  logic [WIDTH:0]                 allocVal2,
  input  logic [ROB:0]                   allocTag1,
  input  logic [ROB:0]                   allocTag2,
  input  logic [CDB_PORTS-1:0]           cdbValid,
  input  logic [CDB_PORTS*(ROB+1)-1:0]   cdbRob,
  input  logic [CDB_PORTS*(WIDTH+1)-1:0] cdbValue,
  output logic                           issueValid,
  input  logic                           issueReady,
  output logic [CTRL:0]                  issueCtrl,
  output logic [ROB:0]                   issueRob,
  output logic [WIDTH:0]                 issueSrc1,
  output logic [WIDTH:0]                 issueSrc2,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = IDXW + 1;

  // Entry storage
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  logic [CTRL:0]    ctrl_q [DEPTH];
  logic [CTRL:0]    ctrl_d [DEPTH];
  logic [ROB:0]     rob_q  [DEPTH];
  logic [ROB:0]     rob_d  [DEPTH];
  logic [ROB:0]     tag1_q [DEPTH];
  logic [ROB:0]     tag1_d [DEPTH];
  logic [ROB:0]     tag2_q [DEPTH];
  logic [ROB:0]     tag2_d [DEPTH];
  logic [WIDTH:0]   val1_q [DEPTH];
  logic [WIDTH:0]   val1_d [DEPTH];
  logic [WIDTH:0]   val2_q [DEPTH];
  logic [WIDTH:0]   val2_d [DEPTH];

`ifdef RS_AGE_SELECT_EN
  // age_q[i][j] set means entry j was already waiting when entry i arrived
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
`endif

  // Issue register and occupancy
  logic             issue_valid_q, issue_valid_d;
  logic [CTRL:0]    issue_ctrl_q, issue_ctrl_d;
  logic [ROB:0]     issue_rob_q, issue_rob_d;
  logic [WIDTH:0]   issue_src1_q, issue_src1_d;
  logic [WIDTH:0]   issue_src2_q, issue_src2_d;
  logic [CNTW-1:0]  count_q, count_d;

  // Control
  logic [ROB:0]     cdb_tag [CDB_PORTS];
  logic [WIDTH:0]   cdb_val [CDB_PORTS];
  logic [DEPTH-1:0] eligible;
  logic             sel_found;
  logic [IDXW-1:0]  sel_idx;
  logic             free_found;
  logic [IDXW-1:0]  free_idx;
  logic             load_en;
  logic             issue_load;
  logic             alloc_fire;

  assign allocReady = (count_q < CNTW'(DEPTH));
  assign load_en    = !issue_valid_q || issueReady;
  assign issue_load = load_en && sel_found;
  assign alloc_fire = allocValid && allocReady && free_found;

  assign issueValid = issue_valid_q;
  assign issueCtrl  = issue_ctrl_q;
  assign issueRob   = issue_rob_q;
  assign issueSrc1  = issue_src1_q;
  assign issueSrc2  = issue_src2_q;
  assign count      = count_q;

  // Split the flat broadcast buses into per-channel tag and value
  always_comb begin
    for (int c = 0; c < CDB_PORTS; c++) begin
      cdb_tag[c] = cdbRob[c*(ROB+1) +: (ROB+1)];
      cdb_val[c] = cdbValue[c*(WIDTH+1) +: (WIDTH+1)];
    end
  end

  // An entry may issue only when both operands were ready at cycle start
  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = busy_q[i] && rdy1_q[i] && rdy2_q[i];
    end
  end

  // Lowest-index free slot receives the next allocation
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  // Pick the eligible entry that has no older eligible entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && ((eligible & age_q[i]) == '0) && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end
`else
  // Pick the lowest-index eligible entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end
`endif

  // Entry next state: wakeup, free on issue, allocation with bypass, flush
  always_comb begin
    busy_d = busy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    ctrl_d = ctrl_q;
    rob_d  = rob_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    val1_d = val1_q;
    val2_d = val2_q;

    // Channels scanned high to low so the lowest matching channel wins
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = CDB_PORTS - 1; c >= 0; c--) begin
        if (busy_q[i] && !rdy1_q[i] && cdbValid[c] && (cdb_tag[c] == tag1_q[i])) begin
          rdy1_d[i] = 1'b1;
          val1_d[i] = cdb_val[c];
        end
        if (busy_q[i] && !rdy2_q[i] && cdbValid[c] && (cdb_tag[c] == tag2_q[i])) begin
          rdy2_d[i] = 1'b1;
          val2_d[i] = cdb_val[c];
        end
      end
    end

    if (issue_load) begin
      busy_d[sel_idx] = 1'b0;
    end

    if (alloc_fire) begin
      busy_d[free_idx] = 1'b1;
      ctrl_d[free_idx] = allocCtrl;
      rob_d[free_idx]  = allocRob;
      rdy1_d[free_idx] = allocRdy1;
      rdy2_d[free_idx] = allocRdy2;
      tag1_d[free_idx] = allocTag1;
      tag2_d[free_idx] = allocTag2;
      val1_d[free_idx] = allocVal1;
      val2_d[free_idx] = allocVal2;
      for (int c = CDB_PORTS - 1; c >= 0; c--) begin
        if (!allocRdy1 && cdbValid[c] && (cdb_tag[c] == allocTag1)) begin
          rdy1_d[free_idx] = 1'b1;
          val1_d[free_idx] = cdb_val[c];
        end
        if (!allocRdy2 && cdbValid[c] && (cdb_tag[c] == allocTag2)) begin
          rdy2_d[free_idx] = 1'b1;
          val2_d[free_idx] = cdb_val[c];
        end
      end
    end

    if (flush) begin
      busy_d = '0;
    end
  end

`ifdef RS_AGE_SELECT_EN
  // New entry is younger than every waiting entry; stale column bits cleared
  always_comb begin
    age_d = age_q;
    if (alloc_fire) begin
      for (int r = 0; r < DEPTH; r++) begin
        age_d[r][free_idx] = 1'b0;
      end
      age_d[free_idx] = busy_q;
    end
  end
`endif

  // Issue register loads when empty or consumed, otherwise holds steady
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_ctrl_d  = issue_ctrl_q;
    issue_rob_d   = issue_rob_q;
    issue_src1_d  = issue_src1_q;
    issue_src2_d  = issue_src2_q;
    if (load_en) begin
      issue_valid_d = sel_found;
      if (sel_found) begin
        issue_ctrl_d = ctrl_q[sel_idx];
        issue_rob_d  = rob_q[sel_idx];
        issue_src1_d = val1_q[sel_idx];
        issue_src2_d = val2_q[sel_idx];
      end
    end
    if (flush) begin
      issue_valid_d = 1'b0;
    end
  end

  // Occupancy tracks entries only, not the issue register
  always_comb begin
    count_d = count_q;
    if (alloc_fire && !issue_load) begin
      count_d = count_q + CNTW'(1);
    end else if (!alloc_fire && issue_load) begin
      count_d = count_q - CNTW'(1);
    end
    if (flush) begin
      count_d = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      busy_q        <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        rob_q[i]  <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
        age_q[i]  <= '0;
`endif
      end
      issue_valid_q <= 1'b0;
      issue_ctrl_q  <= '0;
      issue_rob_q   <= '0;
      issue_src1_q  <= '0;
      issue_src2_q  <= '0;
      count_q       <= '0;
    end else begin
      busy_q        <= busy_d;
      rdy1_q        <= rdy1_d;
      rdy2_q        <= rdy2_d;
      ctrl_q        <= ctrl_d;
      rob_q         <= rob_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
`ifdef RS_AGE_SELECT_EN
      age_q         <= age_d;
`endif
      issue_valid_q <= issue_valid_d;
      issue_ctrl_q  <= issue_ctrl_d;
      issue_rob_q   <= issue_rob_d;
      issue_src1_q  <= issue_src1_d;
      issue_src2_q  <= issue_src2_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_unified_reservation_station.sv
// Directed bench for unified_reservation_station with an issue scoreboard.
module tb_unified_reservation_station;

  logic        clk;
  logic        globalReset_n;
  logic        allocValid;
  logic        allocReady;
  logic [7:0]  allocCtrl;
  logic [2:0]  allocRob;
  logic        allocRdy1;
  logic        allocRdy2;
  logic [31:0] allocVal1;
  logic [31:0] allocVal2;
  logic [2:0]  allocTag1;
  logic [2:0]  allocTag2;
  logic [1:0]  cdbValid;
  logic [5:0]  cdbRob;
  logic [63:0] cdbValue;
  logic        issueValid;
  logic        issueReady;
  logic [7:0]  issueCtrl;
  logic [2:0]  issueRob;
  logic [31:0] issueSrc1;
  logic [31:0] issueSrc2;
  logic        flush;
  logic [2:0]  count;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [2:0]  rob;
    logic [31:0] src1;
    logic [31:0] src2;
  } expIssue_t;

  expIssue_t expQ[$];
  int checks = 0;
  int errors = 0;

  unified_reservation_station #(
    .WIDTH(31), .ROB(2), .CTRL(7), .DEPTH(4), .CDB_PORTS(2)
  ) dut (
    .clk(clk),
    .globalReset_n(globalReset_n),
    .allocValid(allocValid),
    .allocReady(allocReady),
    .allocCtrl(allocCtrl),
    .allocRob(allocRob),
    .allocRdy1(allocRdy1),
    .allocRdy2(allocRdy2),
    .allocVal1(allocVal1),
    .allocVal2(allocVal2),
    .allocTag1(allocTag1),
    .allocTag2(allocTag2),
    .cdbValid(cdbValid),
    .cdbRob(cdbRob),
    .cdbValue(cdbValue),
    .issueValid(issueValid),
    .issueReady(issueReady),
    .issueCtrl(issueCtrl),
    .issueRob(issueRob),
    .issueSrc1(issueSrc1),
    .issueSrc2(issueSrc2),
    .flush(flush),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] ctrl,
                               input logic [2:0] rob,
                               input logic rdy1, input logic [31:0] val1,
                               input logic [2:0] tag1,
                               input logic rdy2, input logic [31:0] val2,
                               input logic [2:0] tag2);
    allocValid = valid;
    allocCtrl  = ctrl;
    allocRob   = rob;
    allocRdy1  = rdy1;
    allocVal1  = val1;
    allocTag1  = tag1;
    allocRdy2  = rdy2;
    allocVal2  = val2;
    allocTag2  = tag2;
  endtask

  task automatic clearAlloc();
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd0);
  endtask

  task automatic driveCdb(input logic [1:0] valid, input logic [2:0] tag0,
                          input logic [31:0] val0, input logic [2:0] tag1,
                          input logic [31:0] val1);
    cdbValid = valid;
    cdbRob   = {tag1, tag0};
    cdbValue = {val1, val0};
  endtask

  // One clock edge; a handshake seen before the edge is scored after it
  task automatic tick();
    logic      fire;
    expIssue_t got;
    expIssue_t want;
    fire = issueValid && issueReady;
    got  = '{ctrl: issueCtrl, rob: issueRob, src1: issueSrc1, src2: issueSrc2};
    @(posedge clk);
    #1;
    if (fire) begin
      checkOutput("sb_expected_issue", 64'(expQ.size() != 0), 64'(1));
      if (expQ.size() != 0) begin
        want = expQ.pop_front();
        checkOutput("sb_ctrl", 64'(got.ctrl), 64'(want.ctrl));
        checkOutput("sb_rob",  64'(got.rob),  64'(want.rob));
        checkOutput("sb_src1", 64'(got.src1), 64'(want.src1));
        checkOutput("sb_src2", 64'(got.src2), 64'(want.src2));
      end
    end
  endtask

  initial begin
    globalReset_n = 1'b0;
    issueReady    = 1'b0;
    flush         = 1'b0;
    clearAlloc();
    driveCdb(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    globalReset_n = 1'b1;

    $display("[TB] reset values");
    checkOutput("rst_issueValid", 64'(issueValid), 64'(0));
    checkOutput("rst_allocReady", 64'(allocReady), 64'(1));
    checkOutput("rst_count",      64'(count),      64'(0));
    checkOutput("rst_issueCtrl",  64'(issueCtrl),  64'(0));
    checkOutput("rst_issueRob",   64'(issueRob),   64'(0));
    checkOutput("rst_issueSrc1",  64'(issueSrc1),  64'(0));
    checkOutput("rst_issueSrc2",  64'(issueSrc2),  64'(0));

    $display("[TB] ready alloc, two-edge latency");
    issueReady = 1'b1;
    applyStimulus(1'b1, 8'h11, 3'd3, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0);
    expQ.push_back('{ctrl: 8'h11, rob: 3'd3, src1: 32'd5, src2: 32'd7});
    tick();
    clearAlloc();
    checkOutput("t1_count_after_alloc", 64'(count), 64'(1));
    checkOutput("t1_not_yet_valid", 64'(issueValid), 64'(0));
    tick();
    checkOutput("t1_valid", 64'(issueValid), 64'(1));
    checkOutput("t1_rob",   64'(issueRob),   64'(3));
    checkOutput("t1_src1",  64'(issueSrc1),  64'(5));
    checkOutput("t1_src2",  64'(issueSrc2),  64'(7));
    checkOutput("t1_count", 64'(count),      64'(0));
    tick();
    checkOutput("t1_drained", 64'(issueValid), 64'(0));

    $display("[TB] wakeup on channel 1");
    applyStimulus(1'b1, 8'h22, 3'd1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h10, 3'd0);
    expQ.push_back('{ctrl: 8'h22, rob: 3'd1, src1: 32'h55, src2: 32'h10});
    tick();
    clearAlloc();
    tick();
    checkOutput("t2_waiting", 64'(issueValid), 64'(0));
    driveCdb(2'b10, 3'd0, 32'h0, 3'd2, 32'h55);
    tick();
    driveCdb(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    checkOutput("t2_woken_not_issued", 64'(issueValid), 64'(0));
    tick();
    checkOutput("t2_valid", 64'(issueValid), 64'(1));
    checkOutput("t2_src1",  64'(issueSrc1),  64'(32'h55));
    tick();

    $display("[TB] fill, full, wake in order");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(8'h30 + k), 3'(4 + k), 1'b0, 32'h0, 3'(k),
                    1'b1, 32'(k), 3'd0);
      expQ.push_back('{ctrl: 8'(8'h30 + k), rob: 3'(4 + k),
                       src1: 32'(32'h100 + k), src2: 32'(k)});
      tick();
    end
    checkOutput("t3_count_full", 64'(count),      64'(4));
    checkOutput("t3_not_ready",  64'(allocReady), 64'(0));
    applyStimulus(1'b1, 8'hEE, 3'd0, 1'b1, 32'hDEAD, 3'd0, 1'b1, 32'hBEEF, 3'd0);
    tick();
    tick();
    clearAlloc();
    checkOutput("t3_ignored_count", 64'(count), 64'(4));
    driveCdb(2'b11, 3'd0, 32'h100, 3'd1, 32'h101);
    tick();
    driveCdb(2'b11, 3'd2, 32'h102, 3'd3, 32'h103);
    tick();
    driveCdb(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    checkOutput("t3_first_rob",   64'(issueRob),   64'(4));
    checkOutput("t3_count_after", 64'(count),      64'(3));
    checkOutput("t3_ready_again", 64'(allocReady), 64'(1));
    repeat (5) tick();
    checkOutput("t3_empty_valid", 64'(issueValid), 64'(0));
    checkOutput("t3_empty_count", 64'(count),      64'(0));

    $display("[TB] allocation bypass on channel 0");
    applyStimulus(1'b1, 8'h44, 3'd2, 1'b1, 32'h1, 3'd0, 1'b0, 32'h0, 3'd6);
    driveCdb(2'b01, 3'd6, 32'h99, 3'd0, 32'h0);
    expQ.push_back('{ctrl: 8'h44, rob: 3'd2, src1: 32'h1, src2: 32'h99});
    tick();
    clearAlloc();
    driveCdb(2'b00, 3'd0, 32'h0, 3'd0, 32'h0);
    checkOutput("t4_count", 64'(count), 64'(1));
    tick();
    checkOutput("t4_valid", 64'(issueValid), 64'(1));
    checkOutput("t4_src2",  64'(issueSrc2),  64'(32'h99));
    tick();

    $display("[TB] stall holds outputs");
    issueReady = 1'b0;
    applyStimulus(1'b1, 8'h55, 3'd5, 1'b1, 32'hA0, 3'd0, 1'b1, 32'hA1, 3'd0);
    expQ.push_back('{ctrl: 8'h55, rob: 3'd5, src1: 32'hA0, src2: 32'hA1});
    tick();
    applyStimulus(1'b1, 8'h66, 3'd6, 1'b1, 32'hB0, 3'd0, 1'b1, 32'hB1, 3'd0);
    expQ.push_back('{ctrl: 8'h66, rob: 3'd6, src1: 32'hB0, src2: 32'hB1});
    tick();
    clearAlloc();
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput("t5_hold_valid", 64'(issueValid), 64'(1));
      checkOutput("t5_hold_rob",   64'(issueRob),   64'(5));
      checkOutput("t5_hold_src1",  64'(issueSrc1),  64'(32'hA0));
      checkOutput("t5_hold_count", 64'(count),      64'(1));
    end
    issueReady = 1'b1;
    tick();
    checkOutput("t5_second_rob",   64'(issueRob),   64'(6));
    checkOutput("t5_second_valid", 64'(issueValid), 64'(1));
    tick();
    checkOutput("t5_drained", 64'(issueValid), 64'(0));

    $display("[TB] flush with simultaneous alloc");
    issueReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(8'h70 + k), 3'(k), 1'b1, 32'(k), 3'd0,
                    1'b1, 32'(k), 3'd0);
      tick();
    end
    clearAlloc();
    checkOutput("t6_pre_count", 64'(count),      64'(3));
    checkOutput("t6_pre_valid", 64'(issueValid), 64'(1));
    flush = 1'b1;
    applyStimulus(1'b1, 8'h7F, 3'd7, 1'b1, 32'h7, 3'd0, 1'b1, 32'h7, 3'd0);
    tick();
    flush = 1'b0;
    clearAlloc();
    checkOutput("t6_valid", 64'(issueValid), 64'(0));
    checkOutput("t6_count", 64'(count),      64'(0));
    checkOutput("t6_ready", 64'(allocReady), 64'(1));
    issueReady = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      checkOutput("t6_no_issue", 64'(issueValid), 64'(0));
    end

    checkOutput("sb_queue_empty", 64'(expQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
